xor_stream_ctrl: RTL
====================

# xor_stream_ctrl

Packet sequencer for the `xor_encrypter` datapath. It accepts a byte stream over valid/ready and drives the encrypter's `key`, `shift` and `din` inputs. The shift is advanced by a programmable step for every byte, and each registered encrypter result is returned on an output valid/ready stream. It sits between a byte source (UART/FIFO) and a byte sink, and owns the encrypter instance's inputs exclusively.

## Interface
- `SHIFT_STEP`, default 1: shift increment per byte, taken mod 8. Legal range 0..7.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `key_in` in 8: key value, captured on `key_load`.
- `key_load` in 1: loads `key_in` into the key register. Honoured only in IDLE.
- `shift_base` in 3: shift used for byte 0, captured on `start`.
- `len` in 8: packet length in bytes, captured on `start`. 0 means empty packet.
- `start` in 1: begins a packet. Honoured only in IDLE.
- `abort` in 1: cancels the packet. Returns to IDLE.
- `s_valid` in 1: input byte valid.
- `s_data` in 8: input byte.
- `s_ready` out 1: controller accepts `s_data`.
- `m_valid` out 1: output byte valid.
- `m_data` out 8: encrypted byte.
- `m_ready` in 1: sink accepts `m_data`.
- `enc_key` out 8: to encrypter `key`.
- `enc_shift` out 3: to encrypter `shift`.
- `enc_din` out 8: to encrypter `din`.
- `enc_dout` in 8: from encrypter `dout`. Registered, 1-cycle latency.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a packet completes.
- `byte_cnt` out 8: bytes delivered in the current or last packet.

## Operation
- FSM states: IDLE, LOAD, WAIT, OUT, FIN.
- IDLE:
  - `key_load` sets key_reg to `key_in`.
  - `start` with `len` != 0 captures `len` and `shift_base` (cur_shift = `shift_base`), clears `byte_cnt`, and goes to LOAD.
  - `start` with `len` == 0 goes to FIN.
  - If `start` and `key_load` arrive together, both take effect.
- LOAD: `s_ready` = 1. On `s_valid` the controller latches `s_data` into din_reg and goes to WAIT.
- WAIT: `s_ready` = 0. This single cycle lets the encrypter register din_reg. The FSM always goes to OUT.
- OUT:
  - `m_valid` = 1 and `m_data` = `enc_dout` (combinational pass-through).
  - On `m_ready`: `byte_cnt`++, cur_shift = (cur_shift + `SHIFT_STEP`) mod 8 with 3-bit wrap.
  - Then go to FIN if `byte_cnt`+1 == `len`, otherwise to LOAD.
- FIN: `done` = 1 for one cycle, then go to IDLE.
- Encrypter inputs:
  - `enc_key` = key_reg, `enc_shift` = cur_shift, `enc_din` = din_reg.
  - All three change only on the LOAD accept edge (din_reg) or the OUT handshake edge (cur_shift).
  - Because the inputs are held stable, `enc_dout` stays stable throughout an OUT stall.
- `abort` has priority over every transition:
  - Any state except IDLE goes to IDLE on the next edge.
  - No `done` pulse is generated. `byte_cnt` holds its value.
  - An in-flight byte is discarded, and `m_valid` drops on that edge.
- `key_load` and `start` arriving outside IDLE are ignored, with no side effect.
- Reset forces IDLE, and key_reg, din_reg, cur_shift, len_reg and `byte_cnt` to 0. All outputs are 0, so `enc_*` = 0.

## Timing
- An input accepted at edge k, with `m_ready` held high, has its output handshake at edge k+2.
- Maximum throughput is 1 byte per 3 cycles.
- `s_ready` and `m_valid` are Moore outputs and never depend combinationally on `s_valid` or `m_ready`.
- `m_valid` stays high and `m_data` stays constant until `m_ready` is sampled high.
- `done` rises on the edge after the final OUT handshake, or the edge after `start` for `len` = 0. `busy` falls on the following edge.
- Shift wrap example, `SHIFT_STEP` = 3, `shift_base` = 6: the byte shifts are 6, 1, 4, 7, 2.
- Asserting `rst_n` low mid-packet clears every state element immediately, without waiting for a clock edge.

## Test plan
- Empty packet: key 0, `start` with `len` = 0 → `done` on the next cycle, no `s_ready`, no `m_valid`, `byte_cnt` = 0.
- Pass-through: key 0, `len` = 4, data 0x11, 0x22, 0x33, 0xFF, `m_ready` = 1 → `m_data` equals the inputs in order, each handshake two edges after its accept, `done` once, `byte_cnt` = 4.
- Shift schedule: key 0xA8, `SHIFT_STEP` = 1, `shift_base` = 5, `len` = 8 → `enc_shift` per byte is 5, 6, 7, 0, 1, 2, 3, 4, and `m_data` matches the encrypter golden model.
- Backpressure: `len` = 2, `m_ready` low for 5 cycles in OUT → `m_valid`, `m_data` and `enc_*` stay constant, and `s_ready` stays 0 throughout.
- Illegal controls: `key_load` to 0x55 and `start` asserted mid-packet → `enc_key` stays at its old value and the packet continues unchanged.
- Abort and reset:
  - `abort` in WAIT of byte 2 of 5 → IDLE next edge, no `done`, `byte_cnt` = 1.
  - A following `start` runs normally.
  - `rst_n` low in OUT → all outputs 0 asynchronously.

Source files
------------

// File: rtl/xor_stream_ctrl_if.sv
// Byte stream valid/ready bundle shared by the sequencer's input and output sides.
interface xor_stream_ctrl_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/xor_stream_ctrl.sv
// Packet sequencer feeding an xor_encrypter: one byte in flight, shift advanced per byte,
// encrypter inputs held stable from accept until the output handshake.
module xor_stream_ctrl #(
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                key_in,
  input  logic                      key_load,
  input  logic [2:0]                shift_base,
  input  logic [7:0]                len,
  input  logic                      start,
  input  logic                      abort,
  xor_stream_ctrl_if.slave          s,
  xor_stream_ctrl_if.master         m,
  output logic [7:0]                enc_key,
  output logic [2:0]                enc_shift,
  output logic [7:0]                enc_din,
  input  logic [7:0]                enc_dout,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                byte_cnt
);

  localparam logic [2:0] STEP = 3'(SHIFT_STEP % 8);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, OUT, FIN} state_t;

  state_t     state, state_nxt;
  logic [7:0] key_reg;
  logic [7:0] din_reg;
  logic [2:0] cur_shift;
  logic [7:0] len_reg;
  logic       last_byte;

  assign last_byte = ((byte_cnt + 8'd1) == len_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && !abort) state_nxt = (len == 8'd0) ? FIN : LOAD;
      LOAD: if (s.valid) state_nxt = WAIT;
      WAIT: state_nxt = OUT;
      OUT:  if (m.ready) state_nxt = last_byte ? FIN : LOAD;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // abort overrides any pending transition, including a same-cycle handshake
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg   <= '0;
      din_reg   <= '0;
      cur_shift <= '0;
      len_reg   <= '0;
      byte_cnt  <= '0;
    end else if (state == IDLE) begin
      if (key_load) key_reg <= key_in;
      if (start && !abort) begin
        len_reg  <= len;
        byte_cnt <= '0;
        if (len != 8'd0) cur_shift <= shift_base;
      end
    end else if (!abort) begin
      if (state == LOAD && s.valid) din_reg <= s.data;
      if (state == OUT && m.ready) begin
        byte_cnt  <= byte_cnt + 8'd1;
        cur_shift <= cur_shift + STEP;
      end
    end
  end

  assign s.ready   = (state == LOAD);
  assign m.valid   = (state == OUT);
  // gated so m.data reads 0 outside OUT, including during reset
  assign m.data    = (state == OUT) ? enc_dout : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign enc_key   = key_reg;
  assign enc_shift = cur_shift;
  assign enc_din   = din_reg;

endmodule
